// File: rtl/rr_grant_fsm.sv
// Four-client round-robin arbiter with bounded hold time. Each grant is followed by
// one RELEASE cycle and then one IDLE cycle, and a new client wins in that IDLE cycle.
module rr_grant_fsm #(
  parameter int HOLD_MAX = 16,
  parameter int CW       = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] owner,
  output logic       busy,
  output logic       start,
  output logic [1:0] start_id,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);

  state_t          state_reg, state_next;
  logic [1:0]      owner_reg, owner_next;
  logic [1:0]      ptr_reg, ptr_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [1:0]      winner;
  logic [1:0]      idx;
  logic            start_raw, timeout_raw;
  logic [1:0]      start_id_raw;
  logic [3:0]      gnt_raw;

  // Scan from farthest to nearest so the client closest after ptr wins.
  always_comb begin
    winner = ptr_reg;
    idx    = ptr_reg;
    for (int k = 4; k >= 1; k--) begin
      idx = ptr_reg + 2'(k);
      if (req[idx]) winner = idx;
    end
  end

  always_comb begin
    state_next   = state_reg;
    owner_next   = owner_reg;
    ptr_next     = ptr_reg;
    cnt_next     = cnt_reg;
    start_raw    = 1'b0;
    start_id_raw = 2'd0;
    timeout_raw  = 1'b0;
    gnt_raw      = 4'b0000;
    case (state_reg)
      IDLE: begin
        if (req != 4'b0000) begin
          start_raw    = 1'b1;
          start_id_raw = winner;
          owner_next   = winner;
          cnt_next     = '0;
          state_next   = GRANT;
        end
      end
      GRANT: begin
        gnt_raw  = 4'b0001 << owner_reg;
        cnt_next = cnt_reg + 1'b1;
        if (!req[owner_reg]) begin
          state_next = RELEASE;
        end else if (cnt_reg == HOLD_LAST) begin
          state_next  = RELEASE;
          timeout_raw = 1'b1;
        end
      end
      RELEASE: begin
        ptr_next   = owner_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      owner_reg <= 2'd0;
      ptr_reg   <= 2'd3;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      ptr_reg   <= ptr_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Mealy pulses are masked so nothing fires while reset is held with requests pending.
  assign start    = start_raw & ~reset;
  assign start_id = reset ? 2'd0 : start_id_raw;
  assign timeout  = timeout_raw & ~reset;
  assign gnt      = gnt_raw;
  assign owner    = owner_reg;
  assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_rr_grant_fsm.sv
// Directed and random stimulus for rr_grant_fsm, checked every cycle against a
// transaction-level model (current owner, cycles held, release gap, last served).
module tb_rr_grant_fsm;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] owner;
  logic       busy, start, timeout;
  logic [1:0] start_id;

  int n_cmp = 0;
  int n_err = 0;

  // Model state
  int m_cur = -1;       // client currently holding the resource, -1 if none
  int m_held = 0;       // cycles the current client has held it
  int m_gap = 0;        // release cycles still to pass before arbitration
  int m_last = 3;       // last client served
  int m_owner = 0;      // visible owner index

  logic [3:0] e_gnt;
  logic [1:0] e_owner, e_sid;
  logic       e_busy, e_start, e_to;

  int to_seen;
  int sid_q[$];

  rr_grant_fsm #(.HOLD_MAX(HOLD), .CW(3)) dut (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt), .owner(owner),
    .busy(busy), .start(start), .start_id(start_id), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cur = -1; m_held = 0; m_gap = 0; m_last = 3; m_owner = 0;
  endtask

  // Expected outputs for this cycle, then advance the model to the next cycle.
  task automatic model_cycle(input logic [3:0] r);
    int w;
    e_gnt = 4'b0000; e_busy = 1'b0; e_start = 1'b0; e_sid = 2'd0; e_to = 1'b0;
    e_owner = 2'(m_owner);
    if (m_cur >= 0) begin
      e_gnt  = 4'b0001 << m_cur;
      e_busy = 1'b1;
      m_held++;
      if (!r[m_cur] || m_held == HOLD) begin
        e_to   = r[m_cur] ? 1'b1 : 1'b0;
        m_last = m_cur;
        m_cur  = -1;
        m_gap  = 1;
      end
    end else if (m_gap > 0) begin
      e_busy = 1'b1;
      m_gap  = 0;
    end else if (r != 4'b0000) begin
      w = -1;
      for (int k = 1; k <= 4; k++)
        if (w < 0 && r[(m_last + k) % 4]) w = (m_last + k) % 4;
      e_start = 1'b1;
      e_sid   = 2'(w);
      m_cur   = w;
      m_held  = 0;
      m_owner = w;
    end
  endtask

  task automatic cyc(input logic [3:0] r);
    @(negedge clk);
    req = r;
    #1;
    model_cycle(r);
    check("gnt", gnt, e_gnt);
    check("owner", {2'b00, owner}, {2'b00, e_owner});
    check("busy", {3'b000, busy}, {3'b000, e_busy});
    check("start", {3'b000, start}, {3'b000, e_start});
    check("start_id", {2'b00, start_id}, {2'b00, e_sid});
    check("timeout", {3'b000, timeout}, {3'b000, e_to});
    if (start) sid_q.push_back(int'(start_id));
    if (timeout) to_seen++;
    $display("t=%0t req=%b gnt=%b owner=%0d busy=%b start=%b id=%0d to=%b",
             $time, req, gnt, owner, busy, start, start_id, timeout);
  endtask

  // Asserted between clock edges so the asynchronous clear is visible immediately.
  task automatic do_reset();
    req = 4'b1111;
    reset = 1'b1;
    #1;
    check("rst_gnt", gnt, 4'b0000);
    check("rst_busy", {3'b000, busy}, 4'b0000);
    check("rst_start", {3'b000, start}, 4'b0000);
    check("rst_start_id", {2'b00, start_id}, 4'b0000);
    check("rst_timeout", {3'b000, timeout}, 4'b0000);
    check("rst_owner", {2'b00, owner}, 4'b0000);
    model_reset();
    @(negedge clk);
    req = 4'b0000;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] r;
    #2;
    do_reset();

    // Single request with drop
    cyc(4'b0001);
    check("single_start", {3'b000, start}, 4'b0001);
    cyc(4'b0001);
    check("single_gnt", gnt, 4'b0001);
    cyc(4'b0001);
    cyc(4'b0000);
    check("single_gnt_last", gnt, 4'b0001);
    cyc(4'b0000);
    check("single_gnt_off", gnt, 4'b0000);
    check("single_busy_rel", {3'b000, busy}, 4'b0001);
    cyc(4'b0000);
    check("single_busy_off", {3'b000, busy}, 4'b0000);

    // Rotation with all requesters active
    do_reset();
    sid_q.delete();
    to_seen = 0;
    for (int i = 0; i < 26; i++) cyc(4'b1111);
    check("rot_count", 4'(sid_q.size()), 4'd5);
    if (sid_q.size() >= 5) begin
      check("rot0", 4'(sid_q[0]), 4'd0);
      check("rot1", 4'(sid_q[1]), 4'd1);
      check("rot2", 4'(sid_q[2]), 4'd2);
      check("rot3", 4'(sid_q[3]), 4'd3);
      check("rot4", 4'(sid_q[4]), 4'd0);
    end
    check("rot_timeouts", 4'(to_seen), 4'd4);

    // Skip over client 0 after client 1 releases
    do_reset();
    cyc(4'b0010);
    cyc(4'b0010);
    cyc(4'b0000);
    cyc(4'b0000);
    cyc(4'b1001);
    check("skip_id3", {2'b00, start_id}, 4'd3);
    cyc(4'b1000);
    cyc(4'b0000);
    cyc(4'b0000);
    cyc(4'b1001);
    check("skip_id0", {2'b00, start_id}, 4'd0);

    // Lone requester times out and is re-granted
    do_reset();
    to_seen = 0;
    for (int i = 0; i < 12; i++) cyc(4'b0100);
    check("lone_timeouts", 4'(to_seen), 4'd2);

    // Owner drops on the final hold cycle
    do_reset();
    cyc(4'b0001);
    cyc(4'b0001);
    cyc(4'b0001);
    cyc(4'b0001);
    cyc(4'b0000);
    check("coinc_gnt", gnt, 4'b0001);
    check("coinc_timeout", {3'b000, timeout}, 4'b0000);
    cyc(4'b0000);

    // Reset in the middle of a grant to client 1
    do_reset();
    cyc(4'b0010);
    cyc(4'b0010);
    check("mid_gnt", gnt, 4'b0010);
    do_reset();
    cyc(4'b1111);
    check("mid_after_id", {2'b00, start_id}, 4'd0);
    cyc(4'b1111);
    check("mid_after_gnt", gnt, 4'b0001);

    // Random traffic with sticky requests and occasional resets
    r = 4'b0000;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 30) r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 399) == 0) do_reset();
      cyc(r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
